// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: one operation in flight, registered
// operands and results. Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [CTRL_WIDTH-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]      req0_a,
  input  logic [WIDTH-1:0]      req0_b,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [CTRL_WIDTH-1:0] req1_ctrl,
  input  logic [WIDTH-1:0]      req1_a,
  input  logic [WIDTH-1:0]      req1_b,

  output logic [CTRL_WIDTH-1:0] alu_control,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_overflow,
  input  logic                  alu_zero,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_overflow,
  output logic                  rsp_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t state;
  logic   cur_id;
  logic   gnt0, gnt1;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic   last_grant;
`endif

  // Grant is purely a function of state, valids and arbitration history; rsp_ready
  // never feeds back into acceptance.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && rst_n) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt0 = req0_valid;
      gnt1 = req1_valid & ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
`endif
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_id       <= 1'b0;
      alu_control  <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            alu_control <= gnt1 ? req1_ctrl : req0_ctrl;
            alu_a       <= gnt1 ? req1_a    : req0_a;
            alu_b       <= gnt1 ? req1_b    : req0_b;
            cur_id      <= gnt1;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant  <= gnt1;
`endif
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_result   <= alu_result;
          rsp_carry    <= alu_carry;
          rsp_overflow <= alu_overflow;
          rsp_zero     <= alu_zero;
          rsp_id       <= cur_id;
          rsp_valid    <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
